// File: rtl/move_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg: shared direction/state encodings for the move permit arbiter. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package move_pkg;

  localparam int unsigned DENY_CNT_W = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2,
    COOL = 2'd3
  } arb_state_e;

endpackage : move_pkg

`default_nettype wire

// File: rtl/grid_and_reduce.sv
// -----------------------------------------------------------------------------
// grid_and_reduce: registered AND-reduction of one direction's obj & wall grid. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module grid_and_reduce
  import move_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] obj_en,
  input  logic [WIDTH-1:0] wall_en,
  output logic             permit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      permit <= 1'b0;
    end else begin
      permit <= &(obj_en & wall_en);
    end
  end

endmodule : grid_and_reduce

`default_nettype wire

// File: rtl/move_permit_arbiter.sv
// -----------------------------------------------------------------------------
// move_permit_arbiter: per-direction move permits plus request/grant FSM with cooldown.
// Optional deny counters under MOVE_PERMIT_DENY_CNT_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module move_permit_arbiter
  import move_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 6,
  parameter int unsigned DIRS     = 4,
  parameter int unsigned COOLDOWN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIRS*ROWS*COLS-1:0]  obj_en_i,
  input  logic [DIRS*ROWS*COLS-1:0]  wall_en_i,
  input  logic                       req_valid_i,
  input  logic [1:0]                 req_dir_i,
  output logic                       req_ready_o,
  output logic                       grant_valid_o,
  output logic [1:0]                 grant_dir_o,
  output logic                       grant_ok_o,
  output logic [DIRS-1:0]            permit_o,
  output logic                       busy_o,
  input  logic                       deny_clr_i,
  output logic [DIRS*DENY_CNT_W-1:0] deny_cnt_o
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] COOL_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  logic [DIRS-1:0]  permit_q;
  logic [3:0]       permit_ext;
  arb_state_e       state;
  dir_e             dir_q;
  logic             ok_q;
  logic [CNT_W-1:0] cool_cnt;
  logic             grant_valid_q;
  logic [1:0]       grant_dir_q;
  logic             grant_ok_q;

  generate
    for (genvar d = 0; d < DIRS; d++) begin : g_dir
      grid_and_reduce #(
        .WIDTH (CELLS)
      ) u_reduce (
        .clk     (clk),
        .rst_n   (rst_n),
        .obj_en  (obj_en_i[d*CELLS +: CELLS]),
        .wall_en (wall_en_i[d*CELLS +: CELLS]),
        .permit  (permit_q[d])
      );
    end
  endgenerate

  // Unused upper directions read as 0 so an out-of-range request is denied.
  always_comb begin
    permit_ext           = '0;
    permit_ext[DIRS-1:0] = permit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir_q         <= DIR_UP;
      ok_q          <= 1'b0;
      cool_cnt      <= '0;
      grant_valid_q <= 1'b0;
      grant_dir_q   <= 2'd0;
      grant_ok_q    <= 1'b0;
    end else begin
      grant_valid_q <= 1'b0;
      grant_dir_q   <= 2'd0;
      grant_ok_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            dir_q <= dir_e'(req_dir_i);
            state <= EVAL;
          end
        end
        EVAL: begin
          ok_q          <= permit_ext[dir_q];
          grant_valid_q <= 1'b1;
          grant_dir_q   <= dir_q;
          grant_ok_q    <= permit_ext[dir_q];
          state         <= RESP;
        end
        RESP: begin
          if (ok_q && (COOLDOWN > 0)) begin
            cool_cnt <= COOL_LOAD;
            state    <= COOL;
          end else begin
            state <= IDLE;
          end
        end
        COOL: begin
          if (cool_cnt == '0) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so the handshake stays quiet while reset is held.
  assign req_ready_o   = rst_n && (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign grant_valid_o = grant_valid_q;
  assign grant_dir_o   = grant_dir_q;
  assign grant_ok_o    = grant_ok_q;
  assign permit_o      = permit_q;

`ifdef MOVE_PERMIT_DENY_CNT_EN
  generate
    for (genvar d = 0; d < DIRS; d++) begin : g_deny
      logic [DENY_CNT_W-1:0] cnt_q;
      logic                  hit;

      assign hit = (state == RESP) && !ok_q && (dir_q == dir_e'(d));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (deny_clr_i) begin
          cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
          cnt_q <= cnt_q + DENY_CNT_W'(1);
        end
      end

      assign deny_cnt_o[d*DENY_CNT_W +: DENY_CNT_W] = cnt_q;
    end
  endgenerate
`else
  logic unused_deny_clr;
  assign unused_deny_clr = deny_clr_i;
  assign deny_cnt_o      = '0;
`endif

endmodule : move_permit_arbiter

`default_nettype wire
